// File: rtl/calc_display.sv
// calc_display: converts the calculator result word to five BCD digits with a
// sequential double-dabble engine (one iteration per clock) and scans them onto
// a 5-digit common-anode seven-segment display with leading-zero blanking.
module calc_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dataIn,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg,
  output logic [4:0]  an
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [15:0]   last_q;
  logic [15:0]   cap_q;
  logic [15:0]   orig_q;
  logic [19:0]   work_q;
  logic [19:0]   bcd_q;
  logic [3:0]    cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [19:0]   work_adj_d;
  logic [RW-1:0] rcnt_q;
  logic [2:0]    dig_q;
  logic [3:0]    digit_d;
  logic          blank_d;
  logic [6:0]    seg_d;
  logic [4:0]    an_d;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [19:0] dabble_adjust(input logic [19:0] w);
    logic [19:0] r;
    r = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      if (w[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = w[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = w[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Seven-segment decode, active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Corrected accumulator feeding the next shift step.
  always_comb begin
    work_adj_d = dabble_adjust(work_q);
  end

  // Conversion FSM: detect a new value, run 16 shift iterations, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 16'h0000;
      cap_q   <= 16'h0000;
      orig_q  <= 16'h0000;
      work_q  <= 20'h00000;
      bcd_q   <= 20'h00000;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dataIn != last_q) begin
            cap_q   <= dataIn;
            orig_q  <= dataIn;
            work_q  <= 20'h00000;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CONV: begin
          // The MSB of the capture register shifts into the BCD accumulator.
          work_q <= {work_adj_d[18:0], cap_q[15]};
          cap_q  <= {cap_q[14:0], 1'b0};
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_CONV;
          end
        end
        S_DONE: begin
          bcd_q   <= work_q;
          last_q  <= orig_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Display scan: each digit stays lit for REFRESH_DIV cycles, then advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      dig_q  <= 3'd0;
    end else if (rcnt_q == RCNT_LAST) begin
      rcnt_q <= '0;
      if (dig_q == 3'd4) begin
        dig_q <= 3'd0;
      end else begin
        dig_q <= dig_q + 3'd1;
      end
    end else begin
      rcnt_q <= rcnt_q + {{(RW-1){1'b0}}, 1'b1};
    end
  end

  // Select the lit digit and decide whether it is a leading zero.
  always_comb begin
    digit_d = 4'd0;
    blank_d = 1'b0;
    case (dig_q)
      3'd0: begin
        digit_d = bcd_q[3:0];
        blank_d = 1'b0;
      end
      3'd1: begin
        digit_d = bcd_q[7:4];
        blank_d = (bcd_q[19:4] == 16'h0000);
      end
      3'd2: begin
        digit_d = bcd_q[11:8];
        blank_d = (bcd_q[19:8] == 12'h000);
      end
      3'd3: begin
        digit_d = bcd_q[15:12];
        blank_d = (bcd_q[19:12] == 8'h00);
      end
      3'd4: begin
        digit_d = bcd_q[19:16];
        blank_d = (bcd_q[19:16] == 4'h0);
      end
      default: begin
        digit_d = 4'd0;
        blank_d = 1'b1;
      end
    endcase
  end

  // Segment and anode drive for the currently lit digit.
  always_comb begin
    an_d = ~(5'b00001 << dig_q);
    if (blank_d) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = seg_decode(digit_d);
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign seg  = seg_d;
  assign an   = an_d;

endmodule

// File: tb/tb_calc_display.sv
// Self-checking bench for calc_display: directed test-plan scenarios with literal
// expectations plus randomized input changes, all compared every cycle against a
// value-level behavioural model.
module tb_calc_display;

  localparam int RD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] dataIn;
  logic [19:0] bcd;
  logic        busy;
  logic        done;
  logic [6:0]  seg;
  logic [4:0]  an;

  int n_tests = 0;
  int n_fail  = 0;

  calc_display #(.REFRESH_DIV(RD)) dut (
    .clk    (clk),
    .rst    (rst),
    .dataIn (dataIn),
    .bcd    (bcd),
    .busy   (busy),
    .done   (done),
    .seg    (seg),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          pow10 [5] = '{1, 10, 100, 1000, 10000};
  logic [6:0]  segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int m_left = 0;    // cycles until the pending result appears
  int m_last = 0;    // value the display currently reflects
  int m_cap  = 0;
  int m_val  = 0;
  int m_cyc  = 0;    // clock edges since reset released
  bit m_done = 1'b0;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = 20'h00000;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_left = 0; m_last = 0; m_cap = 0; m_val = 0; m_cyc = 0; m_done = 1'b0;
      end else begin
        m_cyc++;
        m_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_val  = m_cap;
            m_last = m_cap;
            m_done = 1'b1;
          end
        end else if (int'(dataIn) != m_last) begin
          m_cap  = int'(dataIn);
          m_left = 17;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    int         d;
    logic [6:0] es;
    d = (m_cyc / RD) % 5;
    if (d > 0 && m_val < pow10[d]) es = 7'h7F;
    else es = segtab[(m_val / pow10[d]) % 10];
    chk("bcd",  {12'h0, bcd},  {12'h0, to_bcd(m_val)});
    chk("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
    chk("done", {31'h0, done}, {31'h0, m_done});
    chk("an",   {27'h0, an},   {27'h0, ~(5'b00001 << d)});
    chk("seg",  {25'h0, seg},  {25'h0, es});
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [15:0] v);
    @(negedge clk);
    #2 dataIn = v;
  endtask

  initial begin
    logic [4:0] prev_an;
    logic [4:0] exp_an;
    int r;
    rst = 1'b1;
    dataIn = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_an",   {27'h0, an},   {27'h0, 5'b11110});
    chk("rst_seg",  {25'h0, seg},  {25'h0, 7'h40});
    chk("rst_bcd",  {12'h0, bcd},  32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("rst_nodone", {31'h0, done}, 32'h0);
    end

    // full scale
    set_in(16'hFFFF);
    repeat (16) @(posedge clk);
    #1 chk("fs_busy", {31'h0, busy}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("fs_bcd",  {12'h0, bcd},  32'h65535);
    chk("fs_done", {31'h0, done}, 32'h1);
    chk("fs_busyfall", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    chk("fs_pulse", {31'h0, done}, 32'h0);

    // mid-conversion change
    set_in(16'd100);
    repeat (5) @(posedge clk);
    #2 dataIn = 16'd42;
    repeat (13) @(posedge clk);
    #1;
    chk("mid_bcd1",  {12'h0, bcd},  32'h00100);
    chk("mid_done1", {31'h0, done}, 32'h1);
    repeat (18) @(posedge clk);
    #1;
    chk("mid_bcd2",  {12'h0, bcd},  32'h00042);
    chk("mid_done2", {31'h0, done}, 32'h1);

    // blanking and scan sequence with value 7
    set_in(16'd7);
    repeat (18) @(posedge clk);
    #1 chk("scan_bcd", {12'h0, bcd}, 32'h00007);
    prev_an = an;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (an == 5'b11110 && prev_an != 5'b11110) break;
      prev_an = an;
    end
    chk("scan_sync", {27'h0, an}, {27'h0, 5'b11110});
    for (int d = 0; d < 5; d++) begin
      exp_an = ~(5'b00001 << d);
      for (int c = 0; c < RD; c++) begin
        chk("scan_an",  {27'h0, an},  {27'h0, exp_an});
        chk("scan_seg", {25'h0, seg}, (d == 0) ? 32'h78 : 32'h7F);
        @(posedge clk); #1;
      end
    end

    // internal zeros
    set_in(16'd10203);
    repeat (18) @(posedge clk);
    #1 chk("iz_bcd", {12'h0, bcd}, 32'h10203);
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (an == 5'b11101) chk("iz_dig1", {25'h0, seg}, 32'h40);
      if (an == 5'b10111) chk("iz_dig3", {25'h0, seg}, 32'h40);
      if (an == 5'b01111) chk("iz_dig4", {25'h0, seg}, 32'h79);
    end

    // reset mid-conversion
    set_in(16'd999);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rm_bcd",  {12'h0, bcd},  32'h0);
    chk("rm_done", {31'h0, done}, 32'h0);
    chk("rm_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    chk("rm_bcd2",  {12'h0, bcd},  32'h00999);
    chk("rm_done2", {31'h0, done}, 32'h1);

    // randomized input changes and occasional resets
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        @(negedge clk);
        #2 rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
      end else begin
        @(negedge clk);
        if (r < 4) #2 dataIn = 16'($urandom_range(0, 99));
        else       #2 dataIn = 16'($urandom_range(0, 65535));
        repeat ($urandom_range(1, 40)) @(posedge clk);
      end
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
